rom_fetch: RTL and testbench

//   Instruction fetch sequencer between the 16-bit synchronous program ROM and the core.
//   - Drives the ROM halfword address and consumes rom_q (one-cycle read latency).
//   - Assembles little-endian 32-bit instructions from two consecutive halfwords.
//   - Offers each instruction to the core with a valid/ready handshake.
//   - Supports redirect (jump/branch) to a new PC at any time.

---
 rtl/rom_fetch.sv | 129 ++++++++++++
 tb/tb_rom_fetch.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_fetch.sv
// rtl/rom_fetch.sv - instruction fetch sequencer from 16-bit synchronous ROM to core
//
// Fetches two consecutive halfwords from a one-cycle-latency program ROM,
// pairs them little-endian into a 32-bit instruction and offers it to the
// core over a valid/ready handshake. A redirect restarts fetch at a new PC.
//
// Ports:
//   clk          in   system clock, all state on rising edge
//   reset        in   asynchronous active-high reset
//   rom_addr     out  halfword address to the ROM (combinational from state/pc)
//   rom_q        in   ROM read data, valid one cycle after rom_addr is sampled
//   redirect     in   load redirect_pc and restart fetch (highest priority)
//   redirect_pc  in   new byte PC; low two bits forced to zero
//   instr        out  assembled instruction {hi_half, lo_half}
//   instr_pc     out  byte PC of instr
//   instr_valid  out  instr/instr_pc valid
//   instr_ready  in   core accepts instr when instr_valid && instr_ready
module rom_fetch #(
    parameter int                  ADDR_WIDTH = 14,
    parameter logic [ADDR_WIDTH:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [15:0]           rom_q,
    input  logic                  redirect,
    input  logic [ADDR_WIDTH:0]   redirect_pc,
    output logic [31:0]           instr,
    output logic [ADDR_WIDTH:0]   instr_pc,
    output logic                  instr_valid,
    input  logic                  instr_ready
);

    localparam logic [1:0] S_LO    = 2'd0;
    localparam logic [1:0] S_HI    = 2'd1;
    localparam logic [1:0] S_CAP   = 2'd2;
    localparam logic [1:0] S_VALID = 2'd3;

    localparam logic [ADDR_WIDTH:0] PC_ALIGN_MASK = ~(ADDR_WIDTH+1)'(3);
    localparam logic [ADDR_WIDTH:0] PC_STEP       = (ADDR_WIDTH+1)'(4);

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH:0]   pc_q, pc_d;
    logic [15:0]           lo_q, lo_d;
    logic [31:0]           instr_q, instr_d;
    logic [ADDR_WIDTH:0]   instr_pc_q, instr_pc_d;
    logic                  instr_valid_q, instr_valid_d;

    // pc is always word aligned, so hw[0] is 0 and hw+1 is just hw with bit 0 set.
    logic [ADDR_WIDTH-1:0] hw;
    assign hw = pc_q[ADDR_WIDTH:1];

    always_comb begin
        rom_addr = hw;
        case (state_q)
            S_LO:    rom_addr = hw;
            S_HI:    rom_addr = {hw[ADDR_WIDTH-1:1], 1'b1};
            S_CAP:   rom_addr = {hw[ADDR_WIDTH-1:1], 1'b1};
            // Prefetch address of the next instruction; wraps with the PC.
            S_VALID: rom_addr = hw + ADDR_WIDTH'(2);
            default: rom_addr = hw;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        lo_d          = lo_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;

        if (redirect) begin
            // Discards any in-flight halfword and any offered instruction.
            pc_d          = redirect_pc & PC_ALIGN_MASK;
            instr_valid_d = 1'b0;
            state_d       = S_LO;
        end else begin
            case (state_q)
                S_LO: begin
                    state_d = S_HI;
                end
                S_HI: begin
                    lo_d    = rom_q;
                    state_d = S_CAP;
                end
                S_CAP: begin
                    instr_d       = {rom_q, lo_q};
                    instr_pc_d    = pc_q;
                    instr_valid_d = 1'b1;
                    state_d       = S_VALID;
                end
                S_VALID: begin
                    if (instr_ready) begin
                        instr_valid_d = 1'b0;
                        pc_d          = pc_q + PC_STEP;
                        state_d       = S_LO;
                    end
                end
                default: begin
                    state_d = S_LO;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_LO;
            pc_q          <= RESET_PC & PC_ALIGN_MASK;
            lo_q          <= '0;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            lo_q          <= lo_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
        end
    end

    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = instr_valid_q;

endmodule

// File: tb/tb_rom_fetch.sv
// tb/tb_rom_fetch.sv - self-checking bench for rom_fetch
module tb_rom_fetch;
    localparam int AW = 14;
    localparam int PW = 15;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] rom_addr;
    logic [15:0]   rom_q;
    logic          redirect;
    logic [PW-1:0] redirect_pc;
    logic [31:0]   instr;
    logic [PW-1:0] instr_pc;
    logic          instr_valid;
    logic          instr_ready;

    logic [15:0] mem [0:(1<<AW)-1];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model: current fetch PC and the cycle fetch (re)started.
    // An instruction is offered from 3 cycles after the start onward.
    logic [PW-1:0] m_pc;
    int            m_start;

    typedef struct {
        logic [PW-1:0] target;
        logic [PW-1:0] exp_pc;
    } vec_t;
    vec_t vecs [6];

    always #5 clk = ~clk;

    always @(posedge clk) rom_q <= mem[rom_addr];

    rom_fetch #(.ADDR_WIDTH(AW), .RESET_PC('0)) dut (
        .clk         (clk),
        .reset       (reset),
        .rom_addr    (rom_addr),
        .rom_q       (rom_q),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready)
    );

    function automatic logic [31:0] word_at(input logic [PW-1:0] pc);
        logic [AW-1:0] h;
        h = pc[PW-1:1];
        return {mem[h + 1], mem[h]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_check();
        int            age;
        logic [AW-1:0] h;
        age = cyc - m_start;
        h   = m_pc[PW-1:1];
        if (age == 0)      chk("rom_addr_lo", 32'(rom_addr), 32'(h));
        else if (age == 1) chk("rom_addr_hi", 32'(rom_addr), 32'(h + 1));
        else if (age >= 3) chk("rom_addr_next", 32'(rom_addr), 32'(AW'(h + 2)));
        chk("valid", 32'(instr_valid), 32'(age >= 3));
        if (age >= 3) begin
            chk("instr_pc", 32'(instr_pc), 32'(m_pc));
            chk("instr", instr, word_at(m_pc));
        end
    endtask

    task automatic step();
        if (redirect) begin
            m_pc    = redirect_pc & ~PW'(3);
            m_start = cyc + 1;
        end else if ((cyc - m_start) >= 3 && instr_ready) begin
            m_pc    = m_pc + PW'(4);
            m_start = cyc + 1;
        end
        @(posedge clk);
        #1;
        cyc++;
        model_check();
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        instr_ready = 1'b0;
        @(posedge clk);
        #1;
        cyc++;
        chk("rst_valid", 32'(instr_valid), 32'(0));
        chk("rst_instr", instr, 32'h0);
        chk("rst_instr_pc", 32'(instr_pc), 32'(0));
        chk("rst_rom_addr", 32'(rom_addr), 32'(0));
        reset   = 1'b0;
        m_pc    = '0;
        m_start = cyc;
        model_check();
    endtask

    initial begin
        logic [31:0]   held_instr;
        logic [PW-1:0] held_pc;
        int            seen_pc [$];
        int            seen_cyc [$];
        int            stale;

        for (int i = 0; i < (1 << AW); i++) mem[i] = 16'((i * 40503) ^ 23130);
        mem[0] = 16'h0093;
        mem[1] = 16'h0010;

        vecs[0] = '{15'h0106, 15'h0104};
        vecs[1] = '{15'h7fff, 15'h7ffc};
        vecs[2] = '{15'h0003, 15'h0000};
        vecs[3] = '{15'h1234, 15'h1234};
        vecs[4] = '{15'h4001, 15'h4000};
        vecs[5] = '{15'h7ffa, 15'h7ff8};

        // 1: first instruction after reset
        do_reset();
        step(); step();
        chk("t1_not_yet", 32'(instr_valid), 32'(0));
        step();
        chk("t1_valid", 32'(instr_valid), 32'(1));
        chk("t1_instr", instr, 32'h00100093);
        chk("t1_pc", 32'(instr_pc), 32'(0));

        // 2: back-pressure holds everything
        held_instr = instr;
        held_pc    = instr_pc;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("t2_instr", instr, held_instr);
            chk("t2_pc", 32'(instr_pc), 32'(held_pc));
            chk("t2_valid", 32'(instr_valid), 32'(1));
            chk("t2_rom_addr", 32'(rom_addr), 32'(2));
        end

        // 3: streaming with ready tied high
        instr_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (instr_valid) begin
                seen_pc.push_back(int'(instr_pc));
                seen_cyc.push_back(cyc);
            end
            step();
        end
        chk("t3_count", 32'(seen_pc.size()), 32'(4));
        for (int k = 0; k < seen_pc.size(); k++) begin
            chk("t3_pc_seq", 32'(seen_pc[k]), 32'(4 * k));
            if (k > 0) chk("t3_spacing", 32'(seen_cyc[k] - seen_cyc[k-1]), 32'(4));
        end

        // 4: redirect while in S_HI
        instr_ready = 1'b0;
        redirect = 1'b1; redirect_pc = 15'h0040;
        step();
        redirect = 1'b0;
        step();
        redirect = 1'b1; redirect_pc = 15'h0106;
        step();
        redirect = 1'b0;
        step(); step();
        chk("t4_no_stale", 32'(instr_valid), 32'(0));
        step();
        chk("t4_pc", 32'(instr_pc), 32'h0104);
        chk("t4_instr", instr, {mem[14'h83], mem[14'h82]});

        // 5: redirect and ready together while valid
        redirect = 1'b1; redirect_pc = 15'h2000; instr_ready = 1'b1;
        step();
        redirect = 1'b0;
        chk("t5_drop", 32'(instr_valid), 32'(0));
        stale = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (instr_valid && instr_pc == 15'h0108) stale++;
        end
        chk("t5_pc", 32'(instr_pc), 32'h2000);
        chk("t5_no_old", 32'(stale), 32'(0));

        // 6: wrap-around at the top of the address space
        instr_ready = 1'b0;
        redirect = 1'b1; redirect_pc = 15'h7ffc;
        step();
        redirect = 1'b0;
        step(); step(); step();
        chk("t6_top_pc", 32'(instr_pc), 32'h7ffc);
        chk("t6_top_rom_addr", 32'(rom_addr), 32'(0));
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        chk("t6_wrap_rom_addr", 32'(rom_addr), 32'(0));
        step(); step(); step();
        chk("t6_wrap_pc", 32'(instr_pc), 32'(0));

        // Table of redirect targets: alignment and boundary PCs
        for (int v = 0; v < 6; v++) begin
            redirect = 1'b1; redirect_pc = vecs[v].target; instr_ready = 1'b0;
            step();
            redirect = 1'b0;
            step(); step(); step();
            chk("vec_pc", 32'(instr_pc), 32'(vecs[v].exp_pc));
            chk("vec_instr", instr, word_at(vecs[v].exp_pc));
            instr_ready = 1'b1;
            step();
            instr_ready = 1'b0;
        end

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            redirect    = ($urandom_range(0, 15) == 0);
            redirect_pc = ($urandom_range(0, 3) == 0) ? PW'(15'h7ff0 | $urandom_range(0, 15))
                                                      : PW'($urandom);
            instr_ready = ($urandom_range(0, 2) != 0);
            step();
        end

        // Asynchronous reset in the middle of S_HI
        redirect = 1'b1; redirect_pc = 15'h0200; instr_ready = 1'b0;
        step();
        redirect = 1'b0;
        step();
        #3;
        reset = 1'b1;
        #1;
        chk("arst_valid", 32'(instr_valid), 32'(0));
        chk("arst_instr", instr, 32'h0);
        chk("arst_pc", 32'(instr_pc), 32'(0));
        chk("arst_rom_addr", 32'(rom_addr), 32'(0));
        @(posedge clk);
        #1;
        cyc++;
        reset   = 1'b0;
        m_pc    = '0;
        m_start = cyc;
        model_check();
        step(); step(); step();
        chk("arst_restart_instr", instr, 32'h00100093);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
